// File: rtl/npc_pred_pkg.sv
// Shared types and constants for the next-PC predictor: 2-bit counter encodings,
// allocation value, default geometry and the default-width BTB entry layout.
package npc_pred_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_ENTRIES = 64;
  localparam int unsigned DEF_IDX_W   = $clog2(DEF_ENTRIES);
  localparam int unsigned DEF_TAG_W   = DEF_ADDR_W - DEF_IDX_W - 2;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  // Freshly allocated entries start weakly taken.
  localparam ctr_t CTR_ALLOC = WT;

  typedef struct packed {
    logic                  valid;
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_ADDR_W-1:0] target;
    ctr_t                  ctr;
  } btb_entry_t;

endpackage

// File: rtl/npc_sat_ctr.sv
// Combinational 2-bit saturating counter step (up on taken, down on not-taken).
module npc_sat_ctr
  import npc_pred_pkg::*;
(
  input  logic [1:0] ctr_in,
  input  logic       taken,
  output logic [1:0] ctr_out
);

  always_comb begin
    ctr_out = ctr_in;
    if (taken) begin
      if (ctr_in != ST) ctr_out = ctr_in + 2'd1;
    end else begin
      if (ctr_in != SNT) ctr_out = ctr_in - 2'd1;
    end
  end

endmodule

// File: rtl/npc_predictor.sv
// Next-PC selection with a direct-mapped BTB and 2-bit direction counters.
// Optional performance counters are built when NPC_PREDICTOR_PERF_EN is defined.
module npc_predictor
  import npc_pred_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned ENTRIES = DEF_ENTRIES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_if,
  input  logic              jal_id,
  input  logic [ADDR_W-1:0] jal_target,
  input  logic              jalr_ex,
  input  logic [ADDR_W-1:0] jalr_target,
  input  logic              ex_valid,
  input  logic              ex_is_br,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  output logic              pred_taken_if,
  output logic [ADDR_W-1:0] pred_target_if,
  output logic [ADDR_W-1:0] npc,
  output logic              flush,
  output logic [31:0]       perf_br_cnt,
  output logic [31:0]       perf_miss_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    ctr_t              ctr;
  } entry_t;

  entry_t            btb [ENTRIES];
  logic [IDX_W-1:0]  if_idx, ex_idx;
  logic [TAG_W-1:0]  if_tag, ex_tag;
  entry_t            if_ent, ex_ent;
  logic              if_hit, ex_hit, br_ev;
  logic [1:0]        ctr_nxt;

  assign if_idx = pc_if[IDX_W+1:2];
  assign if_tag = pc_if[ADDR_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[ADDR_W-1:IDX_W+2];
  assign if_ent = btb[if_idx];
  assign ex_ent = btb[ex_idx];
  assign if_hit = if_ent.valid && (if_ent.tag == if_tag);
  assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);
  assign br_ev  = ex_valid & ex_is_br;

  assign pred_taken_if  = if_hit & if_ent.ctr[1];
  assign pred_target_if = if_hit ? if_ent.target : pc_if + ADDR_W'(4);

  assign flush = br_ev & ((ex_taken != ex_pred_taken) |
                          (ex_taken & (ex_pred_target != ex_target)));

  always_comb begin
    npc = pred_target_if;
    if (flush)        npc = ex_taken ? ex_target : ex_pc + ADDR_W'(4);
    else if (jalr_ex) npc = jalr_target;
    else if (jal_id)  npc = jal_target;
  end

  npc_sat_ctr u_sat_ctr (
    .ctr_in  (ex_ent.ctr),
    .taken   (ex_taken),
    .ctr_out (ctr_nxt)
  );

  // Lookup reads the array combinationally, so same-index updates land next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) btb[i] <= '0;
    end else if (br_ev) begin
      if (ex_hit) begin
        btb[ex_idx].ctr <= ctr_t'(ctr_nxt);
        if (ex_taken) btb[ex_idx].target <= ex_target;
      end else if (ex_taken) begin
        btb[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: ex_target, ctr: CTR_ALLOC};
      end
    end
  end

`ifdef NPC_PREDICTOR_PERF_EN
  logic [31:0] br_cnt, miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (br_ev && (br_cnt != '1))   br_cnt   <= br_cnt + 32'd1;
      if (flush && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign perf_br_cnt   = br_cnt;
  assign perf_miss_cnt = miss_cnt;
`else
  assign perf_br_cnt   = '0;
  assign perf_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_npc_predictor.sv
// Directed table-driven bench for npc_predictor (default 32-bit, 64-entry build).
module tb_npc_predictor;

`ifdef NPC_PREDICTOR_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_if = '0, jal_target = 32'h700, jalr_target = 32'h600;
  logic        jal_id = 1'b0, jalr_ex = 1'b0;
  logic        ex_valid = 1'b0, ex_is_br = 1'b0, ex_taken = 1'b0, ex_pred_taken = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_target = '0;
  logic        pred_taken_if, flush;
  logic [31:0] pred_target_if, npc, perf_br_cnt, perf_miss_cnt;

  int unsigned n_pass = 0, n_total = 0;

  npc_predictor #(.ADDR_W(32), .ENTRIES(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_if          (pc_if),
    .jal_id         (jal_id),
    .jal_target     (jal_target),
    .jalr_ex        (jalr_ex),
    .jalr_target    (jalr_target),
    .ex_valid       (ex_valid),
    .ex_is_br       (ex_is_br),
    .ex_taken       (ex_taken),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .pred_taken_if  (pred_taken_if),
    .pred_target_if (pred_target_if),
    .npc            (npc),
    .flush          (flush),
    .perf_br_cnt    (perf_br_cnt),
    .perf_miss_cnt  (perf_miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        jal, jalr, ev, isbr, tk;
    logic [31:0] epc, etgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        e_pt;
    logic [31:0] e_ptgt, e_npc;
    logic        e_fl;
    logic [31:0] e_br, e_miss;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", nm, id, act, exp);
  endtask

  task automatic drive(input vec_t v);
    pc_if = v.pc; jal_id = v.jal; jalr_ex = v.jalr;
    ex_valid = v.ev; ex_is_br = v.isbr; ex_taken = v.tk;
    ex_pc = v.epc; ex_target = v.etgt; ex_pred_taken = v.ptk; ex_pred_target = v.ptgt;
  endtask

  initial begin
    // pc jal jalr ev isbr tk epc etgt ptk ptgt | pt ptgt npc fl br miss (perf values before the edge)
    vecs.push_back('{32'h100, 0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h104, 32'h104, 0, 0,0});
    vecs.push_back('{32'h100, 0,0, 1,1,1, 32'h100, 32'h200, 0, 32'h104, 0, 32'h104, 32'h200, 1, 0,0});
    vecs.push_back('{32'h100, 0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   1, 32'h200, 32'h200, 0, 1,1});
    vecs.push_back('{32'h100, 0,0, 1,1,0, 32'h100, 32'h200, 1, 32'h200, 1, 32'h200, 32'h104, 1, 1,1});
    vecs.push_back('{32'h100, 0,0, 1,1,0, 32'h100, 32'h200, 0, 32'h200, 0, 32'h200, 32'h200, 0, 2,2});
    vecs.push_back('{32'h100, 0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h200, 32'h200, 0, 3,2});
    vecs.push_back('{32'h100, 0,0, 1,1,0, 32'h100, 32'h200, 0, 32'h200, 0, 32'h200, 32'h200, 0, 3,2});
    vecs.push_back('{32'h300, 0,0, 1,1,1, 32'h100, 32'h200, 1, 32'h200, 0, 32'h304, 32'h304, 0, 4,2});
    vecs.push_back('{32'h100, 0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h200, 32'h200, 0, 5,2});
    vecs.push_back('{32'hFFFFFFFC, 0,0, 0,0,0, 32'h0, 32'h0, 0, 32'h0,  0, 32'h0,   32'h0,   0, 5,2});
    vecs.push_back('{32'h100, 1,1, 1,1,1, 32'h400, 32'h500, 0, 32'h404, 0, 32'h200, 32'h500, 1, 5,2});
    vecs.push_back('{32'h100, 1,1, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h104, 32'h600, 0, 6,3});
    vecs.push_back('{32'h400, 1,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   1, 32'h500, 32'h700, 0, 6,3});
    vecs.push_back('{32'h400, 0,0, 1,1,1, 32'h400, 32'h580, 1, 32'h500, 1, 32'h500, 32'h580, 1, 6,3});
    vecs.push_back('{32'h400, 0,0, 1,0,1, 32'h400, 32'h900, 0, 32'h0,   1, 32'h580, 32'h580, 0, 7,4});
    vecs.push_back('{32'h400, 0,0, 1,1,1, 32'h400, 32'h580, 1, 32'h580, 1, 32'h580, 32'h580, 0, 7,4});
    vecs.push_back('{32'h400, 0,0, 1,1,0, 32'h400, 32'h580, 1, 32'h580, 1, 32'h580, 32'h404, 1, 8,4});
    vecs.push_back('{32'h400, 0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   1, 32'h580, 32'h580, 0, 9,5});

    pc_if = 32'h100;
    #1;
    chk("rst_pred_taken", -1, 32'(pred_taken_if), 32'h0);
    chk("rst_pred_target", -1, pred_target_if, 32'h104);
    chk("rst_perf_br", -1, perf_br_cnt, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk("pred_taken_if", i, 32'(pred_taken_if), 32'(vecs[i].e_pt));
      chk("pred_target_if", i, pred_target_if, vecs[i].e_ptgt);
      chk("npc", i, npc, vecs[i].e_npc);
      chk("flush", i, 32'(flush), 32'(vecs[i].e_fl));
      chk("perf_br_cnt", i, perf_br_cnt, PERF ? vecs[i].e_br : 32'h0);
      chk("perf_miss_cnt", i, perf_miss_cnt, PERF ? vecs[i].e_miss : 32'h0);
    end

    // Reset asserted while a taken-branch allocation is pending must cancel it.
    @(negedge clk);
    drive('{32'h400, 0,0, 1,1,1, 32'h804, 32'hA00, 0, 32'h808, 0, 32'h0, 32'h0, 0, 0,0});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_pred_taken", 100, 32'(pred_taken_if), 32'h0);
    chk("rst_async_pred_target", 100, pred_target_if, 32'h404);
    chk("rst_async_perf_br", 100, perf_br_cnt, 32'h0);
    chk("rst_async_perf_miss", 100, perf_miss_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive('{32'h804, 0,0, 0,0,0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0,0});
    #1;
    chk("rst_cancel_pred_taken", 101, 32'(pred_taken_if), 32'h0);
    chk("rst_cancel_pred_target", 101, pred_target_if, 32'h808);
    chk("rst_cancel_npc", 101, npc, 32'h808);
    pc_if = 32'h400;
    #1;
    chk("rst_cleared_pred_taken", 102, 32'(pred_taken_if), 32'h0);
    chk("rst_cleared_pred_target", 102, pred_target_if, 32'h404);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
